binary_mul_acc_bi: RTL and testbench
====================================

// Module: binary_mul_acc_bi
// PURPOSE
//  Downstream accumulator for the signed binary multiplier stage. Consumes a stream of signed
//  products, sums LEN consecutive products with saturation and emits one signed frame sum.
//  Valid/ready handshake on both sides; sticky per-frame saturation flag. Feeds dot-product/MAC consumers.
// PARAMETERS
//  P_W    6   width of signed product input (multiplier output width)
//  ACC_W  10  width of signed accumulator / output; must be >= P_W+1
//  LEN    8   products per frame; must be >= 1
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      global enable; 0 freezes every register, forces in_ready=0
//  clr        in   1      synchronous frame abort
//  in_valid   in   1      product valid
//  in_data    in   P_W    signed product
//  in_ready   out  1      product accepted when in_valid & in_ready
//  out_valid  out  1      frame sum valid
//  out_ready  in   1      downstream accepts when out_valid & out_ready & en
//  out_data   out  ACC_W  signed saturated frame sum
//  out_sat    out  1      saturation occurred at least once in this frame
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=ACC, acc=0, cnt=0, sat_flag=0, out_valid=0, out_data=0, out_sat=0.
//  - Priority per cycle: rst > en=0 (hold all) > clr > normal operation.
//  - in_ready = en & (state==ACC), combinational from registered state.
//  - ACC: on accept, acc_n = sat(acc + sext(in_data)); cnt increments.
//    sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; a clamp sets sat_flag.
//  - Accept with cnt==LEN-1: out_data<=acc_n, out_sat<=sat_flag|clamp_now, out_valid<=1,
//    acc<=0, cnt<=0, sat_flag<=0, state->HOLD. Latency: out_valid high in cycle after LENth accept.
//  - HOLD: in_ready=0, out_data/out_sat stable; on out_valid&out_ready&en: out_valid<=0,
//    state->ACC; next product can be accepted in the following cycle (no same-cycle pass-through).
//  - Gaps (in_valid=0) in ACC: acc/cnt hold; frames need not be back-to-back.
//  - clr: acc=0, cnt=0, sat_flag=0, out_valid=0, state->ACC; a pending HOLD result is dropped;
//    an in_valid in the clr cycle is not accepted.
//  - rst mid-frame or in HOLD: partial sum and pending result discarded, reset values as above.
//  - LEN=1: every accepted product produces a frame (out_data = in_data sign-extended).
//  - out_data/out_sat only change on frame completion, clr or rst.
// STRUCTURE
//  - Shared package binary_mul_pkg: state encodings ST_ACC=1'b0, ST_HOLD=1'b1;
//    default product width constant (P_W=6) shared with the multiplier.
//  - Sub-module binary_mul_sat_add: combinational signed saturating adder
//    (ACC_W acc + P_W operand -> ACC_W sum, clamp flag).
//  - Top: 2-state FSM, frame counter of width $clog2(LEN)+1, output registers.
// TESTING (defaults unless noted)
//  1 rst=1 two cycles, en=1 -> out_valid=0, out_data=0, out_sat=0; in_ready=1 after rst drops.
//  2 products 1..8 back-to-back, out_ready=1 -> out_valid one cycle after 8th accept, out_data=36, out_sat=0.
//  3 ACC_W=7: 8x +16 -> out_data=63, out_sat=1; next frame 8x -16 -> out_data=-64, out_sat=1;
//    next frame 8x +1 -> out_data=8, out_sat=0 (flag cleared per frame).
//  4 frame complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable,
//    no accepts; out_ready=1 -> handshake, next frame accepts from following cycle.
//  5 accept 5,5,5 then clr=1 one cycle, then 8x +1 -> out_data=8; clr in HOLD -> out_valid drops.
//  6 en=0 for 4 cycles mid-frame with in_valid=1 -> no accepts, cnt frozen; products 1..8 still sum
//    to 36; rst asserted after 3 accepts -> next full frame of 2s gives out_data=16.

Source files
------------

// File: rtl/binary_mul_pkg.sv
// Shared definitions for the signed binary multiplier and its downstream accumulator.
// The FSM state encoding and the default product width live here so both stages agree.
package binary_mul_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_t;

  localparam int P_W_DEFAULT = 6;

endpackage

// File: rtl/binary_mul_sat_add.sv
// Combinational signed saturating adder: ACC_W-bit accumulator plus P_W-bit operand,
// clamped to the ACC_W-bit signed range, with a flag whenever the clamp engages.
module binary_mul_sat_add #(
  parameter int P_W   = 6,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   operand,
  output logic [ACC_W-1:0] sum,
  output logic             clamp
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;

  // One guard bit is enough: operand width is strictly below the accumulator width.
  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-P_W){operand[P_W-1]}}, operand};

  always_comb begin
    clamp = wide[ACC_W] ^ wide[ACC_W-1];
    sum   = wide[ACC_W-1:0];
    if (clamp) begin
      sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/binary_mul_acc_bi.sv
// Frame accumulator: sums LEN signed products with saturation and presents one frame sum
// plus a sticky per-frame saturation flag over a valid/ready handshake.
module binary_mul_acc_bi
  import binary_mul_pkg::*;
#(
  parameter int P_W   = P_W_DEFAULT,
  parameter int ACC_W = 10,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [P_W-1:0]   in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high
  // and en is high; valid never waits on ready, and data is stable while valid is held.

  localparam int CNT_W = $clog2(LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_d;
  logic [ACC_W-1:0] out_data_d;
  logic             out_sat_d;

  logic [ACC_W-1:0] sum_now;
  logic             clamp_now;

  binary_mul_sat_add #(
    .P_W  (P_W),
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc    (acc_q),
    .operand(in_data),
    .sum    (sum_now),
    .clamp  (clamp_now)
  );

  assign in_ready = en & (state_q == ST_ACC);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    if (clr) begin
      // Abort wins over any accept or pending result in the same cycle.
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
              out_data_d  = sum_now;
              out_sat_d   = sat_q | clamp_now;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              sat_d       = 1'b0;
              state_d     = ST_HOLD;
            end else begin
              acc_d = sum_now;
              cnt_d = cnt_q + CNT_W'(1);
              sat_d = sat_q | clamp_now;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // en=0 freezes every register, which also gates both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sat   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_binary_mul_acc_bi.sv
// Bench for binary_mul_acc_bi: a default DUT (ACC_W=10) and a narrow DUT (ACC_W=7) share inputs.
module tb_binary_mul_acc_bi;

  localparam int P_W = 6;
  localparam int LEN = 8;
  localparam int AW  = 10;
  localparam int BW  = 7;

  logic          clk = 1'b0;
  logic          rst, en, clr, in_valid, out_ready;
  logic [P_W-1:0] in_data;
  logic          a_in_ready, a_out_valid, a_out_sat;
  logic [AW-1:0] a_out_data;
  logic          b_in_ready, b_out_valid, b_out_sat;
  logic [BW-1:0] b_out_data;

  int checks = 0;
  int failures = 0;

  logic [AW:0] exp_a_q[$];
  logic [BW:0] exp_b_q[$];

  always #5 clk = ~clk;

  binary_mul_acc_bi #(.P_W(P_W), .ACC_W(AW), .LEN(LEN)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat)
  );

  binary_mul_acc_bi #(.P_W(P_W), .ACC_W(BW), .LEN(LEN)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat)
  );

  // Scoreboard: pop one expectation per output handshake on each DUT.
  always @(negedge clk) begin
    if (!rst && en && out_ready && a_out_valid) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        failures++;
        $display("FAIL sb_a_unexpected: got {sat,data}=%h, none expected", {a_out_sat, a_out_data});
      end else begin
        logic [AW:0] e;
        e = exp_a_q.pop_front();
        if ({a_out_sat, a_out_data} !== e) begin
          failures++;
          $display("FAIL sb_a: got {sat,data}=%h expected %h", {a_out_sat, a_out_data}, e);
        end
      end
    end
    if (!rst && en && out_ready && b_out_valid) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        failures++;
        $display("FAIL sb_b_unexpected: got {sat,data}=%h, none expected", {b_out_sat, b_out_data});
      end else begin
        logic [BW:0] e;
        e = exp_b_q.pop_front();
        if ({b_out_sat, b_out_data} !== e) begin
          failures++;
          $display("FAIL sb_b: got {sat,data}=%h expected %h", {b_out_sat, b_out_data}, e);
        end
      end
    end
  end

  // Reference: sequential saturating sum in a w-bit signed accumulator.
  function automatic void frame_model(input int vals[LEN], input int w, output int sum, output bit sat);
    int mx, mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    sum = 0;
    sat = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      sum = sum + vals[i];
      if (sum > mx) begin sum = mx; sat = 1'b1; end
      if (sum < mn) begin sum = mn; sat = 1'b1; end
    end
  endfunction

  // Drivers run at posedge+1; the call returns at posedge+1 right after the accept edge.
  task automatic send(input int d);
    int n;
    in_valid = 1'b1;
    in_data  = P_W'(d);
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 50 cycles", a_in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int vals[LEN]);
    int s;
    bit st;
    frame_model(vals, AW, s, st);
    exp_a_q.push_back({st, AW'(s)});
    frame_model(vals, BW, s, st);
    exp_b_q.push_back({st, BW'(s)});
    for (int i = 0; i < LEN; i++) send(vals[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    wait_cycles(2);
    checks++;
    if ({a_out_valid, a_out_data, a_out_sat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%0d sat=%b required 0/0/0", a_out_valid, a_out_data, a_out_sat);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", a_in_ready);
    end
  endtask

  task automatic test_basic_sum;
    int v[LEN];
    for (int i = 0; i < LEN; i++) v[i] = i + 1;
    run_frame(v);
    checks++;
    if (a_out_valid !== 1'b1 || $signed(a_out_data) !== 36) begin
      failures++;
      $display("FAIL latency_36: got valid=%b data=%0d required 1/36", a_out_valid, $signed(a_out_data));
    end
    wait_cycles(2);
  endtask

  task automatic test_saturation;
    int v[LEN];
    for (int i = 0; i < LEN; i++) v[i] = 16;
    run_frame(v);
    for (int i = 0; i < LEN; i++) v[i] = -16;
    run_frame(v);
    for (int i = 0; i < LEN; i++) v[i] = 1;
    run_frame(v);
    wait_cycles(2);
  endtask

  task automatic test_backpressure;
    int v[LEN];
    for (int i = 0; i < LEN; i++) v[i] = i + 1;
    out_ready = 1'b0;
    run_frame(v);
    in_valid = 1'b1;
    in_data  = P_W'(3);
    for (int c = 0; c < 5; c++) begin
      wait_cycles(1);
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || $signed(a_out_data) !== 36) begin
        failures++;
        $display("FAIL hold_stable: got ready=%b valid=%b data=%0d required 0/1/36", a_in_ready, a_out_valid, $signed(a_out_data));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_cycles(1);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: got ready=%b valid=%b required 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_clr;
    int v[LEN];
    send(5); send(5); send(5);
    clr = 1'b1;
    in_data = P_W'(7);
    wait_cycles(1);
    clr = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < LEN; i++) v[i] = 1;
    run_frame(v);
    wait_cycles(2);
    // Result left pending in HOLD, then aborted: nothing is expected from it.
    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) send(2);
    in_valid = 1'b0;
    clr = 1'b1;
    wait_cycles(1);
    clr = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_hold: got valid=%b ready=%b required 0/1", a_out_valid, a_in_ready);
    end
    out_ready = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_enable_and_rst;
    int v[LEN];
    for (int i = 0; i < LEN; i++) v[i] = i + 1;
    exp_a_q.push_back({1'b0, AW'(36)});
    exp_b_q.push_back({1'b0, BW'(36)});
    send(1); send(2); send(3);
    en = 1'b0;
    in_data = P_W'(9);
    for (int c = 0; c < 4; c++) begin
      wait_cycles(1);
      checks++;
      if (a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL en_freeze: got in_ready=%b required 0", a_in_ready);
      end
    end
    en = 1'b1;
    for (int i = 3; i < LEN; i++) send(v[i]);
    in_valid = 1'b0;
    wait_cycles(2);
    send(2); send(2); send(2);
    in_valid = 1'b0;
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== '0) begin
      failures++;
      $display("FAIL rst_midframe: got valid=%b data=%0d required 0/0", a_out_valid, a_out_data);
    end
    for (int i = 0; i < LEN; i++) v[i] = 2;
    run_frame(v);
    wait_cycles(2);
  endtask

  task automatic test_back_to_back;
    int v[LEN];
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < LEN; i++) v[i] = int'($urandom_range(63)) - 32;
      run_frame(v);
    end
    wait_cycles(3);
  endtask

  initial begin
    test_reset;
    test_basic_sum;
    test_saturation;
    test_backpressure;
    test_clr;
    test_enable_and_rst;
    test_back_to_back;
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d/%0d pending required 0/0", exp_a_q.size(), exp_b_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
